// File: rtl/heap_sift_controller.sv
// Max-heap replace-root sequencer: writes a new root, then sifts it down one
// level at a time against an external 1-cycle-latency RAM.

module comparator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pval,
  input  logic [DATA_WIDTH-1:0] lval,
  input  logic [DATA_WIDTH-1:0] rval,
  output logic                  swap_l,
  output logic                  swap_r
);
  logic l_gt_r;
  // left==right falls to the right; parent equal to a child never swaps
  assign l_gt_r = lval > rval;
  assign swap_l = l_gt_r && (pval < lval);
  assign swap_r = !l_gt_r && (pval < rval);
endmodule

module heap_sift_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic [ADDR_WIDTH:0]   i_size,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data
);
  localparam int IW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE, WR_ROOT, RD_L, RD_R, CMP, WR_P, WR_C, DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] p;
  logic [ADDR_WIDTH-1:0] child;
  logic [DATA_WIDTH-1:0] pval;
  logic [DATA_WIDTH-1:0] lval;
  logic [DATA_WIDTH-1:0] rval;
  logic [ADDR_WIDTH:0]   size;
  logic                  r_read;

  logic [IW-1:0] l_idx, r_idx, gc_idx, size_x;
  logic          swap_l, swap_r;

  // child indices carry two extra bits so 2p+2 / 2c+1 never wrap
  assign l_idx  = {1'b0, p, 1'b1};
  assign r_idx  = l_idx + IW'(1);
  assign gc_idx = {1'b0, child, 1'b1};
  assign size_x = {1'b0, size};
  assign rval   = r_read ? i_rd_data : '0;

  comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .pval  (pval),
    .lval  (lval),
    .rval  (rval),
    .swap_l(swap_l),
    .swap_r(swap_r)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      p         <= '0;
      child     <= '0;
      pval      <= '0;
      lval      <= '0;
      size      <= '0;
      r_read    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      // strobes are set on the edge entering the state they belong to
      o_done  <= 1'b0;
      o_rd_en <= 1'b0;
      o_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (i_size == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              pval      <= i_value;
              p         <= '0;
              size      <= i_size;
              state     <= WR_ROOT;
              o_wr_en   <= 1'b1;
              o_wr_addr <= '0;
              o_wr_data <= i_value;
            end
          end
        end
        WR_ROOT: begin
          if (size <= (ADDR_WIDTH+1)'(1)) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            state     <= RD_L;
            o_rd_en   <= 1'b1;
            o_rd_addr <= ADDR_WIDTH'(1);
          end
        end
        RD_L: begin
          state <= RD_R;
          if (r_idx < size_x) begin
            o_rd_en   <= 1'b1;
            o_rd_addr <= r_idx[ADDR_WIDTH-1:0];
            r_read    <= 1'b1;
          end else begin
            r_read <= 1'b0;
          end
        end
        RD_R: begin
          lval  <= i_rd_data;
          state <= CMP;
        end
        CMP: begin
          if (swap_l) begin
            child     <= l_idx[ADDR_WIDTH-1:0];
            o_wr_data <= lval;
          end else begin
            child     <= r_idx[ADDR_WIDTH-1:0];
            o_wr_data <= rval;
          end
          if (swap_l || swap_r) begin
            state     <= WR_P;
            o_wr_en   <= 1'b1;
            o_wr_addr <= p;
          end else begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        WR_P: begin
          state     <= WR_C;
          o_wr_en   <= 1'b1;
          o_wr_addr <= child;
          o_wr_data <= pval;
        end
        WR_C: begin
          p <= child;
          if (gc_idx >= size_x) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            state     <= RD_L;
            o_rd_en   <= 1'b1;
            o_rd_addr <= gc_idx[ADDR_WIDTH-1:0];
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_heap_sift_controller.sv
// Scoreboard bench for heap_sift_controller: a sift-down reference model
// predicts writes, reads and latency; a negedge monitor checks the DUT.

module tb_heap_sift_controller;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [DW-1:0] i_value;
  logic [AW:0]   i_size;
  logic          o_busy, o_done, o_rd_en, o_wr_en;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] ram     [N];
  logic [DW-1:0] ref_mem [N];

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  int            exp_done[$];

  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int last_lat = 0;
  int n_checks = 0;
  int n_pass = 0;

  heap_sift_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (i_start),
    .i_value  (i_value),
    .i_size   (i_size),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_rd_en  (o_rd_en),
    .o_rd_addr(o_rd_addr),
    .i_rd_data(rd_data),
    .o_wr_en  (o_wr_en),
    .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_wr_en) ram[o_wr_addr] <= o_wr_data;
    if (o_rd_en) rd_data <= ram[o_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: every DUT strobe is matched against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wr_en) begin
        if (exp_wr.size() == 0) chk("unexpected_write", {o_wr_addr, o_wr_data}, '1);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write", {o_wr_addr, o_wr_data}, {w.a, w.d});
        end
      end
      if (o_rd_en) begin
        if (exp_rd.size() == 0) chk("unexpected_read", o_rd_addr, '1);
        else chk("read_addr", o_rd_addr, exp_rd.pop_front());
      end
      if (o_rd_en && o_wr_en) chk("rd_wr_same_addr", o_rd_addr != o_wr_addr, 1);
      if (o_done) begin
        last_lat = cyc - start_cyc;
        if (exp_done.size() == 0) chk("unexpected_done", last_lat, 0);
        else chk("latency", last_lat, exp_done.pop_front());
        done_cnt++;
      end
    end
  end

  // reference: plain sift-down over an array, recording the RAM traffic
  task automatic model(input int sz, input logic [DW-1:0] v);
    int i, l, r, c, k;
    logic [DW-1:0] lv, rv, cv, t;
    wr_t w;
    for (int j = 0; j < N; j++) ref_mem[j] = ram[j];
    if (sz == 0) begin exp_done.push_back(1); return; end
    ref_mem[0] = v;
    w.a = '0; w.d = v; exp_wr.push_back(w);
    if (sz == 1) begin exp_done.push_back(2); return; end
    i = 0; k = 0;
    forever begin
      l = 2*i + 1; r = l + 1;
      exp_rd.push_back(AW'(l));
      lv = ref_mem[l]; rv = '0;
      if (r < sz) begin exp_rd.push_back(AW'(r)); rv = ref_mem[r]; end
      if (lv > rv) begin c = l; cv = lv; end else begin c = r; cv = rv; end
      if (cv <= ref_mem[i]) begin exp_done.push_back(1 + 5*k + 4); return; end
      t = ref_mem[i];
      w.a = AW'(i); w.d = cv; exp_wr.push_back(w);
      w.a = AW'(c); w.d = t;  exp_wr.push_back(w);
      ref_mem[i] = cv; ref_mem[c] = t;
      k++; i = c;
      if (2*i + 1 >= sz) begin exp_done.push_back(1 + 5*k + 1); return; end
    end
  endtask

  task automatic run_op(input int sz, input logic [DW-1:0] v, input bit glitch);
    int snap, bad;
    snap = done_cnt;
    model(sz, v);
    @(negedge clk);
    start_cyc = cyc;
    i_start = 1'b1; i_size = (AW+1)'(sz); i_value = v;
    @(negedge clk);
    i_start = 1'b0; i_value = DW'($urandom);
    chk("busy_after_start", o_busy, 1);
    if (glitch && sz >= 2) begin
      @(negedge clk); i_start = 1'b1; i_size = (AW+1)'($urandom_range(0, N));
      @(negedge clk); i_start = 1'b0;
    end
    for (int t = 0; t < 300 && done_cnt == snap; t++) begin
      @(posedge clk); #2;
    end
    if (done_cnt == snap) chk("done_timeout", 0, 1);
    else chk("idle_after_done", o_busy, 0);
    bad = 0;
    for (int j = 0; j < N; j++) if (ram[j] !== ref_mem[j]) bad++;
    chk("ram_contents", bad, 0);
    chk("queues_drained", exp_wr.size() + exp_rd.size() + exp_done.size(), 0);
  endtask

  task automatic load_heap();
    ram[0] = DW'($urandom_range(0, 15));
    for (int j = 1; j < N; j++) ram[j] = DW'($urandom_range(0, ram[(j-1)/2]));
  endtask

  initial begin
    logic [DW-1:0] exp7 [7];
    int bad;
    rst = 1'b1; i_start = 1'b0; i_value = '0; i_size = '0;
    for (int j = 0; j < N; j++) ram[j] = '0;
    #1;
    chk("reset_outputs", {o_busy, o_done, o_rd_en, o_wr_en, o_rd_addr, o_wr_addr, o_wr_data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // size 0 and size 1
    run_op(0, 8'd5, 0);
    chk("lat_size0", last_lat, 1);
    run_op(1, 8'd7, 0);
    chk("lat_size1", last_lat, 2);
    chk("size1_root", ram[0], 7);

    // no swap at root
    ram[1] = 8'd4; ram[2] = 8'd3;
    run_op(3, 8'd9, 0);
    chk("lat_noswap", last_lat, 5);

    // full sift to a leaf, with a start pulse while busy
    ram[0] = 8'd0; ram[1] = 8'd8; ram[2] = 8'd6; ram[3] = 8'd5;
    ram[4] = 8'd7; ram[5] = 8'd1; ram[6] = 8'd2;
    run_op(7, 8'd3, 1);
    chk("lat_full", last_lat, 12);
    exp7 = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd3, 8'd1, 8'd2};
    bad = 0;
    for (int j = 0; j < 7; j++) if (ram[j] !== exp7[j]) bad++;
    chk("full_final_ram", bad, 0);

    // missing right child, then ties
    ram[1] = 8'd4;
    run_op(2, 8'd1, 0);
    chk("noright_final", {ram[0], ram[1]}, {8'd4, 8'd1});
    ram[1] = 8'd5; ram[2] = 8'd5;
    run_op(3, 8'd2, 0);
    chk("tie_final", {ram[0], ram[1], ram[2]}, {8'd5, 8'd5, 8'd2});
    run_op(3, 8'd5, 0);
    chk("tie_noswap_lat", last_lat, 5);

    // reset during WR_P of level 0
    ram[1] = 8'd8; ram[2] = 8'd6; ram[3] = 8'd5;
    ram[4] = 8'd7; ram[5] = 8'd1; ram[6] = 8'd2;
    model(7, 8'd3);
    @(negedge clk);
    start_cyc = cyc;
    i_start = 1'b1; i_size = 6'd7; i_value = 8'd3;
    @(negedge clk); i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("in_wr_p", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 5'd0, 8'd8});
    bad = done_cnt;
    rst = 1'b1;
    #1;
    chk("reset_mid_outputs", {o_busy, o_done, o_rd_en, o_wr_en, o_rd_addr, o_wr_addr, o_wr_data}, 0);
    exp_wr.delete(); exp_rd.delete(); exp_done.delete();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {o_busy, o_done}, 0);
    chk("no_done_after_reset", done_cnt, bad);
    load_heap();
    run_op(7, 8'd1, 0);

    // randomized heaps, sizes and roots, including full capacity
    for (int n = 0; n < 40; n++) begin
      load_heap();
      run_op((n % 8 == 0) ? N : $urandom_range(0, N), DW'($urandom_range(0, 15)), n[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/heap_sift_controller.md
# heap_sift_controller

Sequencer that runs the max-heap compare/swap datapath against an external BRAM holding the heap array. On a start command it overwrites the root with a new value (the replace-root half of a pop or replace operation), then walks down the tree one level at a time. At each level it reads both children, evaluates parent/left/right through an internal `comparator` instance, writes back any swap, and stops at a leaf or when no swap is needed. It sits between the queue top level and the heap storage RAM.

## Interface
- `DATA_WIDTH`, 32, key width; unsigned compare.
- `ADDR_WIDTH`, 10, heap RAM address width; capacity 2^ADDR_WIDTH entries.

Ports:
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  command strobe; sampled only in IDLE.
- `i_value`  in  DATA_WIDTH  new root value, captured with `i_start`.
- `i_size`  in  ADDR_WIDTH+1  valid heap entries (0..2^ADDR_WIDTH), captured with `i_start`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rd_en`  out  1  RAM read enable.
- `o_rd_addr`  out  ADDR_WIDTH  RAM read address.
- `i_rd_data`  in  DATA_WIDTH  RAM read data, valid the cycle after `o_rd_en`.
- `o_wr_en`  out  1  RAM write enable.
- `o_wr_addr`  out  ADDR_WIDTH  RAM write address.
- `o_wr_data`  out  DATA_WIDTH  RAM write data.

## Operation
- Array layout: 0-indexed. Left child is 2p+1 and right child is 2p+2.
- Child indices are computed in ADDR_WIDTH+2 bits so overflow cannot wrap.
- Registers:
  - `p`: current parent index.
  - `pval`: parent value. Always equals the value at `p`, so the parent is never re-read.
  - `lval`, `rval`: child values.
  - `size`.
- States: IDLE, WR_ROOT, RD_L, RD_R, CMP, WR_P, WR_C, DONE.
- IDLE:
  - If `i_start` and `i_size`==0: go to DONE. No RAM access.
  - If `i_start` and `i_size`≠0: set `pval`=`i_value`, `p`=0, latch `size`, go to WR_ROOT.
- WR_ROOT: write mem[0]=`pval`.
  - If 1≥`size`: go to DONE.
  - Otherwise go to RD_L.
- RD_L: read 2p+1, go to RD_R.
- RD_R:
  - Capture `lval`=`i_rd_data`.
  - If 2p+2<`size`: issue a read of 2p+2.
  - Otherwise assert no read; `rval` is forced to 0.
  - Go to CMP.
- CMP:
  - Capture the right child: `rval`=`i_rd_data` if it was read, else 0.
  - Feed (`pval`, `lval`, `rval`) to the comparator.
  - Left swap (left>right and pval<left): target child = 2p+1, child value = `lval`, go to WR_P.
  - Right swap (otherwise, pval<right): target child = 2p+2, child value = `rval`, go to WR_P.
  - No swap: go to DONE.
  - Ties: left==right selects right. Parent equal to a child means no swap.
- WR_P: write mem[p] = swapped-up child value.
- WR_C:
  - Write mem[child]=`pval`, then set `p`=child.
  - If 2·child+1≥`size`: go to DONE.
  - Otherwise go to RD_L.
- DONE: `o_done`=1, go to IDLE.
- `i_start` outside IDLE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (`o_busy`, `o_done`, `o_rd_en`, `o_wr_en`, addresses, write data). Internal registers are cleared.
- RAM strobes, addresses and write data are registered. They are valid for exactly the state cycle named above, and the RAM acts on the following edge.
- Read latency is 1 cycle. Data for a read issued in RD_L is sampled in RD_R; data for a read issued in RD_R is sampled in CMP.
- At most one read and one write per cycle, and they never target the same address in the same cycle.
- Per-level cost:
  - Swapping level: 5 cycles (RD_L, RD_R, CMP, WR_P, WR_C).
  - Terminating level: 3 cycles plus DONE.
- Latency from the `i_start` sample (cycle 0) to `o_done`:
  - size 0: cycle 1.
  - size 1: cycle 2.
  - no swap at root: cycle 5.
  - k swaps ending at a leaf: 1+5k+1 cycles.
  - k swaps then a no-swap compare: 1+5k+3+1 cycles.
- Reset mid-operation: return to IDLE immediately and drop all strobes. RAM contents are then partially updated and not guaranteed; no `o_done` is issued.

## Test plan
- **Size 0:** `i_size`=0, `i_value`=5 -> `o_done` at cycle 1, no `o_wr_en` or `o_rd_en` ever asserted.
- **Size 1:** `i_size`=1, `i_value`=7 -> single write mem[0]=7 at cycle 1, no reads, `o_done` at cycle 2.
- **No swap:** heap [x,4,3], `i_size`=3, `i_value`=9 -> mem[0]=9, reads of addr 1 and 2, no further writes, `o_done` at cycle 5.
- **Full sift to a leaf:** heap [x,8,6,5,7,1,2], `i_size`=7, `i_value`=3.
  - Final RAM: [8,7,6,5,3,1,2].
  - Writes in order: 0←3, 0←8, 1←3, 1←7, 4←3.
  - `o_done` at cycle 12.
- **Missing right child and ties:**
  - [x,4], `i_size`=2, `i_value`=1 -> right is not read, swap left, final [4,1].
  - [x,5,5], `i_size`=3, `i_value`=2 -> swap right, final [5,5,2].
  - `i_value`=5 on [x,5,5] -> no swap.
- **Robustness:** `i_start` pulsed while busy is ignored. Asserting `i_rst` during WR_P -> all outputs 0 in the same cycle, IDLE afterwards, and a new start then completes normally.
